// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard unit.
package hazard_pkg;

  // Width of the stored destination index; must be >= the top's REGISTER_SIZE.
  localparam int HIST_DEST_W = 5;

  localparam int SRC_A = 0;
  localparam int SRC_B = 1;

  typedef struct packed {
    logic                   valid;
    logic [HIST_DEST_W-1:0] dest;
    logic                   wr_en;
    logic                   is_load;
  } hist_entry_t;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_history.sv
// Shift register of in-flight instructions past decode; entry 1 is execute.
module forwarding_hazard_unit_history
  import hazard_pkg::*;
#(
  parameter int TRACK_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  hist_entry_t                   push_entry,
  output hist_entry_t [TRACK_DEPTH:1]   hist
);

  // NOTE: the history is a handful of flops whose valid bits gate every match,
  // so it is fully reset rather than treated as un-reset storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else begin
      // NOTE: non-blocking assignments let every entry shift from its old value
      // regardless of statement order.
      hist[1] <= push ? push_entry : '0;
      for (int k = 2; k <= TRACK_DEPTH; k++) begin
        hist[k] <= hist[k-1];
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Decode-side operand forwarding select and load-use stall control.
// Optional HAZARD_STATS_EN adds saturating stall/forward counters.
module forwarding_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REGISTER_SIZE = 5,
  parameter int TRACK_DEPTH   = 2,
  parameter int NUM_SRC       = 2,
  parameter int LOAD_LATENCY  = 1,
  parameter int DIST_W        = $clog2(TRACK_DEPTH + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   instr_valid,
  input  logic [REGISTER_SIZE-1:0]               destination_reg,
  input  logic                                   dest_write_en,
  input  logic [NUM_SRC-1:0][REGISTER_SIZE-1:0]  source_reg,
  input  logic [NUM_SRC-1:0]                     source_used,
  input  logic                                   dm_read_enable,
  input  logic                                   flush,
  output logic                                   f_to_d_enable_ff,
  output logic                                   d_to_e_enable_ff,
  output logic                                   d_to_e_bubble,
  output logic [NUM_SRC-1:0][DIST_W-1:0]         forward_dist,
  output logic [NUM_SRC-1:0]                     forward_from_dm
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                            stall_cycles,
  output logic [31:0]                            fwd_alu_count,
  output logic [31:0]                            fwd_dm_count
`endif
);

  hist_entry_t [TRACK_DEPTH:1] hist;
  hist_entry_t                 push_entry;
  logic [NUM_SRC-1:0]          src_stall;
  logic [NUM_SRC-1:0]          found;
  logic                        stall;

  // NOTE: every variable written here gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    src_stall       = '0;
    found           = '0;
    forward_dist    = '0;
    forward_from_dm = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      // Ascending scan with a found flag: the youngest writer wins.
      for (int k = 1; k <= TRACK_DEPTH; k++) begin
        if (!found[s] && instr_valid && source_used[s] && (source_reg[s] != '0) &&
            hist[k].valid && hist[k].wr_en &&
            (hist[k].dest == HIST_DEST_W'(source_reg[s]))) begin
          found[s] = 1'b1;
          if (hist[k].is_load && (k <= LOAD_LATENCY)) begin
            src_stall[s] = 1'b1;
          end else begin
            forward_dist[s]    = DIST_W'(k);
            forward_from_dm[s] = hist[k].is_load;
          end
        end
      end
    end
    if (flush) begin
      forward_dist    = '0;
      forward_from_dm = '0;
    end
  end

  assign stall            = (|src_stall) && !flush;
  assign f_to_d_enable_ff = !stall;
  assign d_to_e_enable_ff = 1'b1;
  assign d_to_e_bubble    = stall;

  assign push_entry.valid   = instr_valid;
  assign push_entry.dest    = HIST_DEST_W'(destination_reg);
  assign push_entry.wr_en   = dest_write_en;
  assign push_entry.is_load = dm_read_enable;

  forwarding_hazard_unit_history #(
    .TRACK_DEPTH(TRACK_DEPTH)
  ) u_history (
    .clk       (clk),
    .rst       (rst),
    .push      (!stall && !flush),
    .push_entry(push_entry),
    .hist      (hist)
  );

`ifdef HAZARD_STATS_EN
  logic [31:0] alu_n;
  logic [31:0] dm_n;

  always_comb begin
    alu_n = '0;
    dm_n  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (forward_dist[s] != '0) begin
        if (forward_from_dm[s]) dm_n  = dm_n + 32'd1;
        else                    alu_n = alu_n + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles  <= '0;
      fwd_alu_count <= '0;
      fwd_dm_count  <= '0;
    end else begin
      stall_cycles  <= sat_add(stall_cycles, {31'd0, !f_to_d_enable_ff});
      fwd_alu_count <= sat_add(fwd_alu_count, alu_n);
      fwd_dm_count  <= sat_add(fwd_dm_count, dm_n);
    end
  end
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed self-checking bench for forwarding_hazard_unit (default parameters).
module tb_forwarding_hazard_unit;

  localparam int RS = 5;
  localparam int NS = 2;
  localparam int DW = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  instr_valid;
  logic [RS-1:0]         destination_reg;
  logic                  dest_write_en;
  logic [NS-1:0][RS-1:0] source_reg;
  logic [NS-1:0]         source_used;
  logic                  dm_read_enable;
  logic                  flush;
  logic                  f_to_d_enable_ff;
  logic                  d_to_e_enable_ff;
  logic                  d_to_e_bubble;
  logic [NS-1:0][DW-1:0] forward_dist;
  logic [NS-1:0]         forward_from_dm;
`ifdef HAZARD_STATS_EN
  logic [31:0]           stall_cycles;
  logic [31:0]           fwd_alu_count;
  logic [31:0]           fwd_dm_count;
`endif

  int checks   = 0;
  int failures = 0;

  forwarding_hazard_unit dut (
    .clk             (clk),
    .rst             (rst),
    .instr_valid     (instr_valid),
    .destination_reg (destination_reg),
    .dest_write_en   (dest_write_en),
    .source_reg      (source_reg),
    .source_used     (source_used),
    .dm_read_enable  (dm_read_enable),
    .flush           (flush),
    .f_to_d_enable_ff(f_to_d_enable_ff),
    .d_to_e_enable_ff(d_to_e_enable_ff),
    .d_to_e_bubble   (d_to_e_bubble),
    .forward_dist    (forward_dist),
    .forward_from_dm (forward_from_dm)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .fwd_alu_count   (fwd_alu_count),
    .fwd_dm_count    (fwd_dm_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one decode instruction; settle before the caller checks.
  task automatic drive(input logic v, input logic [RS-1:0] rd, input logic we,
                       input logic [RS-1:0] a, input logic [RS-1:0] b,
                       input logic [1:0] used, input logic ld, input logic fl);
    instr_valid     = v;
    destination_reg = rd;
    dest_write_en   = we;
    source_reg[0]   = a;
    source_reg[1]   = b;
    source_used     = used;
    dm_read_enable  = ld;
    flush           = fl;
    #1;
  endtask

  task automatic check_out(input string tag, input logic fd, input logic bub,
                           input logic [DW-1:0] da, input logic dma,
                           input logic [DW-1:0] db, input logic dmb);
    check({tag, ".f_to_d"}, {31'd0, f_to_d_enable_ff}, {31'd0, fd});
    check({tag, ".d_to_e"}, {31'd0, d_to_e_enable_ff}, 32'd1);
    check({tag, ".bubble"}, {31'd0, d_to_e_bubble}, {31'd0, bub});
    check({tag, ".dist_a"}, {30'd0, forward_dist[0]}, {30'd0, da});
    check({tag, ".dm_a"},   {31'd0, forward_from_dm[0]}, {31'd0, dma});
    check({tag, ".dist_b"}, {30'd0, forward_dist[1]}, {30'd0, db});
    check({tag, ".dm_b"},   {31'd0, forward_from_dm[1]}, {31'd0, dmb});
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0);
    repeat (2) cyc();
    rst = 1'b0;

    // Empty history: use of x5 finds nothing.
    drive(1, 5'd4, 1, 5'd5, 5'd5, 2'b11, 0, 0);
    check_out("reset_idle", 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    check("stats.reset", stall_cycles, 32'd0);
`endif
    cyc();

    // ADD x5 ; SUB x6,x5,x1 -> forward A from distance 1 ALU.
    drive(1, 5'd5, 1, 5'd1, 5'd2, 2'b11, 0, 0);
    cyc();
    drive(1, 5'd6, 1, 5'd5, 5'd1, 2'b11, 0, 0);
    check_out("alu_d1", 1, 0, 1, 0, 0, 0);
    cyc();

    // LW x7 ; ADD x8,x7,x7 -> one stall cycle, then forward from DM at dist 2.
    drive(1, 5'd7, 1, 5'd0, 5'd0, 2'b00, 1, 0);
    check_out("lw_issue", 1, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 5'd8, 1, 5'd7, 5'd7, 2'b11, 0, 0);
    check_out("lu_stall", 0, 1, 0, 0, 0, 0);
    cyc();
    check_out("lu_resolve", 1, 0, 2, 1, 2, 1);
    cyc();

    // Two writers of x3: nearest wins.
    drive(1, 5'd3, 1, 5'd0, 5'd0, 2'b00, 0, 0);
    cyc();
    drive(1, 5'd3, 1, 5'd0, 5'd0, 2'b00, 0, 0);
    cyc();
    drive(1, 5'd10, 1, 5'd3, 5'd3, 2'b11, 0, 0);
    check_out("nearest", 1, 0, 1, 0, 1, 0);
    cyc();

    // Writer to x0 is never forwarded; wr_en=0 entry never matches.
    drive(1, 5'd0, 1, 5'd0, 5'd0, 2'b00, 0, 0);
    cyc();
    drive(1, 5'd11, 0, 5'd0, 5'd10, 2'b11, 0, 0);
    check_out("x0_src", 1, 0, 0, 0, 2, 0);
    cyc();
    drive(1, 5'd12, 1, 5'd1, 5'd11, 2'b11, 0, 0);
    check_out("no_wren", 1, 0, 0, 0, 0, 0);
    cyc();

    // LW x9 ; dependent use flushed -> no stall, bubble pushed.
    drive(1, 5'd9, 1, 5'd0, 5'd0, 2'b00, 1, 0);
    cyc();
    drive(1, 5'd9, 1, 5'd9, 5'd9, 2'b11, 0, 1);
    check_out("flush", 1, 0, 0, 0, 0, 0);
    cyc();
    drive(1, 5'd14, 1, 5'd9, 5'd0, 2'b01, 0, 0);
    check_out("post_flush", 1, 0, 2, 1, 0, 0);
    cyc();

    // ADD x13 ; LW x12 ; use x12,x13 stalls; reset clears everything.
    drive(1, 5'd13, 1, 5'd0, 5'd0, 2'b00, 0, 0);
    cyc();
    drive(1, 5'd12, 1, 5'd0, 5'd0, 2'b00, 1, 0);
    cyc();
    drive(1, 5'd15, 1, 5'd12, 5'd13, 2'b11, 0, 0);
    check_out("pre_rst", 0, 1, 0, 0, 2, 0);
`ifdef HAZARD_STATS_EN
    check("stats.stalls", stall_cycles, 32'd1);
`endif
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check_out("post_rst", 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    check("stats.cleared", stall_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
